lieat_lsu_memctrl: RTL
======================

Name: lieat_lsu_memctrl

Overview:
- Memory-side controller directly downstream of the execute-stage LSU request/response port.
- Accepts one LSU request at a time (load, store or fence.i) and performs misalignment checking.
- For valid loads and stores, issues a single word-aligned access on a valid/ready memory bus with byte strobes.
- Returns a formatted response: load data shifted and sign- or zero-extended, store ack, or fence.i completion.

Parameters:
XLEN, 32, data/address width (fixed at 32; strobe logic assumes 4 byte lanes)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  block can accept a request
lsu_req_ren  in  1  load
lsu_req_wen  in  1  store
lsu_req_addr  in  32  byte address
lsu_req_flag  in  3  {usign, size[1:0]}; size 00=byte, 01=half, 10=word
lsu_req_wdata  in  32  store data (low-aligned)
lsu_req_fencei  in  1  fence.i request
lsu_rsp_valid  out  1  response valid
lsu_rsp_ready  in  1  response consumed
lsu_rsp_rdata  out  32  formatted load data; 0 for store/fence.i/misaligned
lsu_rsp_misalign  out  1  response carries misaligned-access error
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  1=write, 0=read
mem_req_addr  out  32  word address, {addr[31:2],2'b00}
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte strobes; 0000 for reads
mem_rsp_valid  in  1  bus response valid
mem_rsp_ready  out  1  block accepts bus response
mem_rsp_rdata  in  32  bus read data (whole word)

Behaviour:
- State machine states: IDLE, MREQ, MRSP, RSP. Encoding is one register; all outputs decoded from state and captured registers.
- Reset (reset=0, asynchronous, honoured in any state including mid-transaction):
  - State goes to IDLE; all captured fields clear.
  - mem_req_valid=0, mem_rsp_ready=0, lsu_rsp_valid=0, lsu_rsp_rdata=0, lsu_rsp_misalign=0.
  - lsu_req_ready=1 (IDLE).
  - An outstanding bus response arriving after reset is dropped (mem_rsp_ready=0).
- IDLE:
  - lsu_req_ready=1.
  - On lsu_req_valid, capture ren/wen/fencei, addr, flag and wdata.
  - fencei → RSP (no bus access).
  - misaligned → RSP with misalign=1. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0. Size 11 is treated as word.
  - otherwise → MREQ.
- MREQ:
  - mem_req_valid=1 with stable addr/wen/wdata/wstrb until mem_req_ready; then → MRSP.
  - lsu_req_ready=0.
- MRSP:
  - mem_rsp_ready=1.
  - On mem_rsp_valid, register formatted data (loads) or 0 (stores); then → RSP.
- RSP:
  - lsu_rsp_valid=1; rdata and misalign held stable until lsu_rsp_ready.
  - On the lsu_rsp_ready handshake → IDLE.
  - lsu_req_ready=0 in RSP; no same-cycle turnaround.
- Latency:
  - A request accepted at cycle T with zero-wait bus (ready same cycle, response next cycle) gives lsu_rsp_valid at T+3.
  - fence.i and misaligned requests give lsu_rsp_valid at T+1.
  - Throughput is one request per 4 cycles minimum.
- Store lanes, with off=addr[1:0]:
  - byte: wdata={4{wdata[7:0]}}, wstrb=0001<<off.
  - half: wdata={2{wdata[15:0]}}, wstrb=0011<<off.
  - word: wdata unchanged, wstrb=1111.
- Load format: shifted=mem_rsp_rdata>>(8*off).
  - byte: bits 7:0, sign-extended from bit 7 unless usign.
  - half: bits 15:0, sign-extended from bit 15 unless usign.
  - word: unchanged.
- Request with neither ren nor wen nor fencei: completes via RSP with rdata=0 and no bus access.
- Bus stall: no timeout. MREQ and MRSP wait indefinitely.
- Requests presented while not in IDLE are not accepted, because lsu_req_ready=0.

Test Plan:
- Signed byte load at 0x8000_0003, flag=000, bus returns 0x80FF_1234 → mem_req_addr=0x8000_0000, wstrb=0000, wen=0; lsu_rsp_rdata=0xFFFF_FF80, misalign=0, lsu_rsp_valid 3 cycles after accept.
- Unsigned half load at 0x8000_0002, flag=101, rdata 0xBEEF_0000 → rsp 0x0000_BEEF; same address with flag=001 → 0xFFFF_BEEF.
- Byte store, addr 0x8000_0001, wdata 0x1234_56AB → mem_req_wdata=0xABAB_ABAB, wstrb=0010, wen=1; rsp rdata=0 after bus ack.
- Word load at 0x8000_0002 → no mem_req_valid ever; lsu_rsp_valid next cycle with misalign=1, rdata=0. fence.i → rsp next cycle, misalign=0, no bus activity.
- Backpressure: mem_req_ready low 5 cycles then high, and lsu_rsp_ready low 3 cycles → mem_req fields stable throughout; rsp held stable; lsu_req_ready=0 until the rsp handshake.
- Reset pulse low while in MRSP → outputs return to reset values immediately, state IDLE, lsu_req_ready=1; a late mem_rsp_valid is ignored and no lsu_rsp_valid is produced.

Source files
------------

// File: rtl/lieat_lsu_memctrl.sv
// lieat_lsu_memctrl: one-at-a-time LSU request to word-aligned valid/ready memory bus bridge
// Ports: clock/reset (async, active-low); lsu_req_* request in (ren/wen/fencei, addr, flag, wdata);
// lsu_rsp_* formatted response out (rdata, misalign); mem_req_* aligned bus request with lane-replicated
// data and byte strobes; mem_rsp_* bus read response in.
module lieat_lsu_memctrl #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_req_ren,
  input  logic            lsu_req_wen,
  input  logic [XLEN-1:0] lsu_req_addr,
  input  logic [2:0]      lsu_req_flag,
  input  logic [XLEN-1:0] lsu_req_wdata,
  input  logic            lsu_req_fencei,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [XLEN-1:0] lsu_rsp_rdata,
  output logic            lsu_rsp_misalign,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wstrb,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [XLEN-1:0] mem_rsp_rdata
);
  typedef enum logic [1:0] {IDLE, MREQ, MRSP, RSP} state_t;
  state_t            state_q, state_d;
  logic              ren_q, ren_d, wen_q, wen_d, misal_q, misal_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]        flag_q, flag_d;
  logic              req_mis, req_mem;
  logic [XLEN-1:0]   sh, ld;
  logic [1:0]        off, size;
  assign off  = addr_q[1:0];
  assign size = flag_q[1:0];
  // size 11 falls into the word branch together with 10
  assign req_mis = lsu_req_flag[1] ? |lsu_req_addr[1:0] : (lsu_req_flag[0] & lsu_req_addr[0]);
  assign req_mem = (lsu_req_ren | lsu_req_wen) & ~lsu_req_fencei;
  assign sh = mem_rsp_rdata >> {off, 3'b000};
  assign ld = size == 2'b00 ? {{24{~flag_q[2] & sh[7]}}, sh[7:0]} :
              size == 2'b01 ? {{16{~flag_q[2] & sh[15]}}, sh[15:0]} : sh;
  assign lsu_req_ready    = state_q == IDLE;
  assign mem_req_valid    = state_q == MREQ;
  assign mem_rsp_ready    = state_q == MRSP;
  assign lsu_rsp_valid    = state_q == RSP;
  assign lsu_rsp_rdata    = rdata_q;
  assign lsu_rsp_misalign = misal_q;
  assign mem_req_wen      = wen_q;
  assign mem_req_addr     = {addr_q[XLEN-1:2], 2'b00};
  assign mem_req_wdata    = size == 2'b00 ? {4{wdata_q[7:0]}} :
                            size == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign mem_req_wstrb    = ~wen_q ? 4'b0000 :
                            size == 2'b00 ? 4'b0001 << off :
                            size == 2'b01 ? 4'b0011 << off : 4'b1111;
  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    flag_d  = flag_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    misal_d = misal_q;
    case (state_q)
      IDLE: if (lsu_req_valid) begin
        ren_d   = lsu_req_ren;
        wen_d   = lsu_req_wen;
        addr_d  = lsu_req_addr;
        flag_d  = lsu_req_flag;
        wdata_d = lsu_req_wdata;
        rdata_d = '0;
        misal_d = req_mem & req_mis;
        // fence.i, misaligned and no-op requests answer without touching the bus
        state_d = (req_mem & ~req_mis) ? MREQ : RSP;
      end
      MREQ: if (mem_req_ready) state_d = MRSP;
      MRSP: if (mem_rsp_valid) begin
        rdata_d = (ren_q & ~wen_q) ? ld : '0;
        state_d = RSP;
      end
      RSP: if (lsu_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      flag_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      misal_q <= misal_d;
    end
  end
endmodule
